// File: rtl/tomasulo_pkg.sv
// ---------------------------------------------------------------------------
// tomasulo_pkg
//   Shared types for the Tomasulo core: register/word/tag/ROB-id widths, the
//   per-unit completion request (cdb_req_t) and the Common Data Bus broadcast
//   record (cdb_t). It also provides a small modular-add helper that the
//   round-robin logic uses.
// ---------------------------------------------------------------------------
package tomasulo_pkg;

    // Completion ports that share the CDB: arith0, arith1, logic0, logic1, mpy.
    localparam int CDB_REQ_N = 5;

    typedef logic [4:0]  reg_t;
    typedef logic [31:0] word_t;
    typedef logic [5:0]  tag_t;
    typedef logic [3:0]  robid_t;

    typedef struct packed {
        reg_t   wa;
        word_t  wdata;
        tag_t   tag;
        robid_t robid;
    } cdb_req_t;

    // Field order after vld matches cdb_req_t, so {vld, cdb_req_t} is a cdb_t.
    typedef struct packed {
        logic   vld;
        reg_t   wa;
        word_t  wdata;
        tag_t   tag;
        robid_t robid;
    } cdb_t;

    // (a + b) mod n when both operands are already below n.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/tomasulo_rr_arb.sv
// ---------------------------------------------------------------------------
// tomasulo_rr_arb
//   Pure combinational round-robin picker. The request vector is rotated so
//   the requester at ptr_i becomes bit 0. The lowest set bit is found, and
//   its offset is rotated back into an absolute index.
//
//   req_i    in  N      request vector
//   ptr_i    in  PTR_W  highest-priority index this cycle (must be < N)
//   gnt_o    out N      one-hot grant, zero when no request
//   gnt_id_o out PTR_W  index of the granted requester
//   any_o    out 1      at least one request is present
// ---------------------------------------------------------------------------
module tomasulo_rr_arb
    import tomasulo_pkg::*;
#(
    parameter int N     = CDB_REQ_N,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] gnt_id_o,
    output logic             any_o
);

    logic [N-1:0]     rot;
    logic [PTR_W-1:0] off;
    logic             found;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        rot      = '0;
        off      = '0;
        found    = 1'b0;
        gnt_o    = '0;
        gnt_id_o = '0;

        for (int i = 0; i < N; i++) begin
            rot[PTR_W'(i)] = req_i[PTR_W'(wrap_add(int'(ptr_i), i, N))];
        end

        for (int i = 0; i < N; i++) begin
            if (!found && rot[PTR_W'(i)]) begin
                found = 1'b1;
                off   = PTR_W'(i);
            end
        end

        gnt_id_o = PTR_W'(wrap_add(int'(ptr_i), int'(off), N));
        if (found) gnt_o[gnt_id_o] = 1'b1;
        any_o = found;
    end

endmodule

// File: rtl/tomasulo_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tomasulo_cdb_arbiter
//   Shares the single Common Data Bus among the completion ports. Each cycle
//   it grants at most one pending requester in round-robin order and
//   acknowledges it combinationally. One cycle later it broadcasts that
//   requester's payload on the registered cdb_r.
//
//   clk       in  1            clock
//   rst       in  1            synchronous active-high reset
//   req_vld   in  N            completion pending, held until acknowledged
//   req_data  in  N x cdb_req  payload per requester, stable while pending
//   req_ack   out N            one-hot/zero combinational grant
//   cdb_r     out cdb_t        registered CDB broadcast
//   gnt_id_r  out PTR_W        requester that produced the current cdb_r
//   idle_r    out 1            no grant was issued in the previous cycle
// ---------------------------------------------------------------------------
module tomasulo_cdb_arbiter
    import tomasulo_pkg::*;
#(
    parameter int N     = CDB_REQ_N,
    parameter int PTR_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic     [N-1:0]     req_vld,
    input  cdb_req_t [N-1:0]     req_data,
    output logic     [N-1:0]     req_ack,
    output cdb_t                 cdb_r,
    output logic     [PTR_W-1:0] gnt_id_r,
    output logic                 idle_r
);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             cdb_vld_q;
    cdb_req_t         cdb_pay_q;
    logic [PTR_W-1:0] gnt_id_q;
    logic             idle_q;

    logic [N-1:0]     arb_gnt;
    logic [PTR_W-1:0] arb_id;
    logic             arb_any;
    logic             grant_vld;

    tomasulo_rr_arb #(.N(N), .PTR_W(PTR_W)) u_rr_arb (
        .req_i    (req_vld),
        .ptr_i    (ptr_q),
        .gnt_o    (arb_gnt),
        .gnt_id_o (arb_id),
        .any_o    (arb_any)
    );

    // No grant is issued while reset is held, so a requester never retires
    // a completion that the bus is about to drop.
    assign grant_vld = arb_any && !rst;
    assign req_ack   = rst ? '0 : arb_gnt;

    // Explicit wrap: N need not be a power of two, so the pointer must never
    // count into the unused codes above N-1.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = (arb_id == PTR_W'(N - 1)) ? '0 : arb_id + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
        if (rst) begin
            ptr_q     <= '0;
            cdb_vld_q <= 1'b0;
            gnt_id_q  <= '0;
            idle_q    <= 1'b1;
        end else begin
            ptr_q     <= ptr_d;
            cdb_vld_q <= grant_vld;
            idle_q    <= !grant_vld;
            if (grant_vld) gnt_id_q <= arb_id;
        end
    end

    // NOTE: the payload is a plain data register without reset; consumers qualify it with cdb_r.vld.
    always_ff @(posedge clk) begin
        if (grant_vld) cdb_pay_q <= req_data[arb_id];
    end

    assign cdb_r    = {cdb_vld_q, cdb_pay_q};
    assign gnt_id_r = gnt_id_q;
    assign idle_r   = idle_q;

    // Protocol and structural checks.
    a_ack_onehot : assert property (@(posedge clk) $onehot0(req_ack));
    a_ack_subset : assert property (@(posedge clk) (req_ack & ~req_vld) == '0);
    a_ptr_range  : assert property (@(posedge clk) disable iff (rst) int'(ptr_q) < N);

    for (genvar gi = 0; gi < N; gi++) begin : g_req_chk
        a_no_drop : assert property (@(posedge clk) disable iff (rst)
            (req_vld[gi] && !req_ack[gi]) |=> req_vld[gi]);
        a_stable  : assert property (@(posedge clk) disable iff (rst)
            (req_vld[gi] && !req_ack[gi]) |=> $stable(req_data[gi]));
    end

endmodule
